// File: rtl/ase_tx_wr_arbiter_if.sv
// Requester-side and TX-write-side signal bundle for ase_tx_wr_arbiter.
// The master drives requests and channel status, and the slave is the arbiter.
interface ase_tx_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int HDR_W   = 74,
  parameter int DATA_W  = 512
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [2*NUM_REQ-1:0]      req_len;
  logic [NUM_REQ-1:0]        req_fence;
  logic [HDR_W*NUM_REQ-1:0]  req_hdr;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_full;
  logic                      tx_empty;
  logic                      tx_wr_en;
  logic                      tx_sop;
  logic [HDR_W-1:0]          tx_hdr;
  logic [DATA_W-1:0]         tx_data;
  logic [IW-1:0]             tx_owner;
  logic                      err_illegal_len;

  modport master (
    output req_valid, req_len, req_fence,
    output req_hdr, req_data,
    output tx_full, tx_empty,
    input  req_ready, tx_wr_en, tx_sop,
    input  tx_hdr, tx_data, tx_owner,
    input  err_illegal_len
  );

  modport slave (
    input  req_valid, req_len, req_fence,
    input  req_hdr, req_data,
    input  tx_full, tx_empty,
    output req_ready, tx_wr_en, tx_sop,
    output tx_hdr, tx_data, tx_owner,
    output err_illegal_len
  );
endinterface

// File: rtl/ase_tx_wr_arbiter.sv
// Round-robin TX write arbiter with burst lock and fence drain.
// Beats accepted in one cycle appear registered on the TX side the next.
module ase_tx_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int HDR_W   = 74,
  parameter int DATA_W  = 512
) (
  input logic                clk,
  input logic                rst,
  ase_tx_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FENCE_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]          beats_left_q, beats_left_d;
  logic                tx_wr_en_q;
  logic                tx_sop_q;
  logic [HDR_W-1:0]    tx_hdr_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic [IW-1:0]       tx_owner_q;
  logic                err_q;

  logic [IW-1:0]       winner;
  logic [IW-1:0]       sel;
  logic [IW-1:0]       sel_nxt;
  logic [IW-1:0]       j;
  logic                found;
  logic                drained;
  logic                accept;
  logic                done;
  logic                illegal;
  logic [1:0]          sel_len;
  logic                sel_fence;
  logic [NUM_REQ-1:0]  ready;

  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    j      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[j]) begin
        found  = 1'b1;
        winner = j;
      end
    end
  end

  assign sel       = (state_q == IDLE) ? winner : owner_q;
  assign sel_len   = bus.req_len[2*int'(sel) +: 2];
  assign sel_fence = bus.req_fence[sel];
  assign sel_nxt   = (int'(sel) == NUM_REQ-1) ? '0 : sel + IW'(1);
  // An in-flight push is not yet visible in tx_empty.
  assign drained   = bus.tx_empty && !tx_wr_en_q;

  always_comb begin
    ready        = '0;
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    done         = 1'b0;
    illegal      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          if (sel_fence && !drained) begin
            state_d = FENCE_DRAIN;
            owner_d = sel;
          end else begin
            ready[sel] = !bus.tx_full;
          end
        end
      end
      BURST: begin
        ready[sel] = !bus.tx_full;
      end
      FENCE_DRAIN: begin
        if (!bus.req_valid[sel]) begin
          state_d = IDLE;
        end else if (drained) begin
          ready[sel] = !bus.tx_full;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      ready = '0;
    end

    accept = |(ready & bus.req_valid);

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (!sel_fence && sel_len[0]) begin
            state_d      = BURST;
            owner_d      = sel;
            beats_left_d = sel_len[1] ? 2'd3 : 2'd1;
          end else begin
            done    = 1'b1;
            illegal = !sel_fence && (sel_len == 2'b10);
          end
        end
        BURST: begin
          beats_left_d = beats_left_q - 2'd1;
          if (beats_left_q == 2'd1) begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
        FENCE_DRAIN: begin
          state_d = IDLE;
          done    = 1'b1;
        end
        default: ;
      endcase
    end

    if (done) begin
      rr_ptr_d = sel_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      beats_left_q <= '0;
      tx_wr_en_q   <= 1'b0;
      tx_sop_q     <= 1'b0;
      tx_hdr_q     <= '0;
      tx_data_q    <= '0;
      tx_owner_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
      tx_wr_en_q   <= accept;
      if (accept) begin
        tx_sop_q   <= (state_q != BURST);
        tx_hdr_q   <= bus.req_hdr[HDR_W*int'(sel) +: HDR_W];
        tx_data_q  <= bus.req_data[DATA_W*int'(sel) +: DATA_W];
        tx_owner_q <= sel;
      end
      if (illegal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready       = ready;
  assign bus.tx_wr_en        = tx_wr_en_q;
  assign bus.tx_sop          = tx_sop_q;
  assign bus.tx_hdr          = tx_hdr_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.tx_owner        = tx_owner_q;
  assign bus.err_illegal_len = err_q;
endmodule

// File: tb/tb_ase_tx_wr_arbiter.sv
// Directed bench for ase_tx_wr_arbiter with a beat scoreboard.
// Requester sources hold beat lists; the expected TX order is queued up front.
module tb_ase_tx_wr_arbiter;
  localparam int N  = 4;
  localparam int HW = 74;
  localparam int DW = 512;

  typedef struct packed {
    logic [1:0]  len;
    logic        fence;
    logic [15:0] tag;
  } beat_t;

  typedef struct {
    int          owner;
    logic        sop;
    logic [15:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ase_tx_wr_arbiter_if #(.NUM_REQ(N), .HDR_W(HW), .DATA_W(DW)) bus ();

  ase_tx_wr_arbiter #(.NUM_REQ(N), .HDR_W(HW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  beat_t  src [N][32];
  int     rd [N];
  int     wr [N];
  logic [N-1:0] hold;
  exp_t   expq [$];

  function automatic logic [HW-1:0] hdr_of(logic [15:0] tag);
    logic [HW-1:0] h;
    h = '0;
    h[15:0] = tag;
    h[HW-1 -: 16] = ~tag;
    return h;
  endfunction

  function automatic logic [DW-1:0] data_of(logic [15:0] tag);
    return {32{tag ^ 16'h5A5A}};
  endfunction

  always_comb begin
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.req_fence = '0;
    bus.req_hdr   = '0;
    bus.req_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (rd[i] < wr[i]) begin
        bus.req_valid[i]         = !hold[i];
        bus.req_len[2*i +: 2]    = src[i][rd[i]].len;
        bus.req_fence[i]         = src[i][rd[i]].fence;
        bus.req_hdr[HW*i +: HW]  = hdr_of(src[i][rd[i]].tag);
        bus.req_data[DW*i +: DW] = data_of(src[i][rd[i]].tag);
      end
    end
  end

  task automatic check(string name, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(int r, logic [1:0] len, logic fence, logic [15:0] tag);
    src[r][wr[r]] = '{len: len, fence: fence, tag: tag};
    wr[r]++;
  endtask

  task automatic expect_beat(int owner, logic sop, logic [15:0] tag);
    expq.push_back('{owner: owner, sop: sop, tag: tag});
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) begin
      if (rd[i] < wr[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while ((expq.size() != 0 || !srcs_empty()) && n < 60) begin
      cyc(1);
      n++;
    end
    check(name, DW'(n < 60), DW'(1));
    cyc(1);
  endtask

  task automatic check_reset_outputs(string name);
    @(negedge clk);
    check({name, "_wr_en"}, DW'(bus.tx_wr_en), DW'(0));
    check({name, "_sop"},   DW'(bus.tx_sop), DW'(0));
    check({name, "_hdr"},   DW'(bus.tx_hdr), DW'(0));
    check({name, "_data"},  bus.tx_data, '0);
    check({name, "_owner"}, DW'(bus.tx_owner), DW'(0));
    check({name, "_err"},   DW'(bus.err_illegal_len), DW'(0));
    check({name, "_ready"}, DW'(bus.req_ready), DW'(0));
  endtask

  // Source side: pop a beat once the arbiter has accepted it.
  initial begin
    logic [N-1:0] acc;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && rd[i] < wr[i]) rd[i]++;
      end
    end
  end

  // TX side: every pushed beat must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tx_wr_en === 1'b1) begin
        check("beat_expected", DW'(expq.size() != 0), DW'(1));
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("tx_owner", DW'(bus.tx_owner), DW'(e.owner));
          check("tx_sop",   DW'(bus.tx_sop), DW'(e.sop));
          check("tx_hdr",   DW'(bus.tx_hdr), DW'(hdr_of(e.tag)));
          check("tx_data",  bus.tx_data, data_of(e.tag));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    hold         = '0;
    bus.tx_full  = 1'b0;
    bus.tx_empty = 1'b1;
    rst          = 1'b1;

    cyc(3);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Fairness: all four valid, singles, one beat per cycle
    cyc(1);
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < N; r++) begin
        load(r, 2'b00, 1'b0, 16'(r * 16 + k));
        expect_beat(r, 1'b1, 16'(r * 16 + k));
      end
    end
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("fair_tput", DW'(bus.tx_wr_en), DW'(1));
    end
    wait_drain("fair_drain");

    // Burst lock with a one-cycle owner bubble
    for (int k = 0; k < 4; k++) begin
      load(0, 2'b11, 1'b0, 16'h0100 + 16'(k));
      expect_beat(0, k == 0, 16'h0100 + 16'(k));
    end
    load(1, 2'b00, 1'b0, 16'h011F);
    expect_beat(1, 1'b1, 16'h011F);
    cyc(2);
    hold[0] = 1'b1;
    @(negedge clk);
    check("burst_block", DW'(bus.req_ready), DW'(4'b0001));
    cyc(1);
    hold[0] = 1'b0;
    @(negedge clk);
    check("burst_bubble", DW'(bus.tx_wr_en), DW'(0));
    wait_drain("burst_drain");

    // Backpressure in the middle of a 2-line burst
    load(2, 2'b01, 1'b0, 16'h0220);
    load(2, 2'b01, 1'b0, 16'h0221);
    load(3, 2'b00, 1'b0, 16'h0230);
    expect_beat(2, 1'b1, 16'h0220);
    expect_beat(2, 1'b0, 16'h0221);
    expect_beat(3, 1'b1, 16'h0230);
    cyc(1);
    bus.tx_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", DW'(bus.req_ready), DW'(0));
      cyc(1);
    end
    bus.tx_full = 1'b0;
    @(negedge clk);
    check("bp_resume", DW'(bus.req_ready), DW'(4'b0100));
    wait_drain("bp_drain");

    // Fence held until the channel drains, others blocked
    bus.tx_empty = 1'b0;
    load(2, 2'b00, 1'b1, 16'h032F);
    expect_beat(2, 1'b1, 16'h032F);
    @(negedge clk);
    check("fence_wait", DW'(bus.req_ready), DW'(0));
    cyc(1);
    load(0, 2'b00, 1'b0, 16'h030A);
    load(1, 2'b00, 1'b0, 16'h031A);
    expect_beat(0, 1'b1, 16'h030A);
    expect_beat(1, 1'b1, 16'h031A);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fence_block", DW'(bus.req_ready), DW'(0));
      cyc(1);
    end
    bus.tx_empty = 1'b1;
    @(negedge clk);
    check("fence_go", DW'(bus.req_ready), DW'(4'b0100));
    @(negedge clk);
    check("fence_push", DW'(bus.tx_wr_en), DW'(1));
    wait_drain("fence_drain");

    // Illegal length: single beat, sticky error
    check("err_before", DW'(bus.err_illegal_len), DW'(0));
    load(3, 2'b10, 1'b0, 16'h043B);
    expect_beat(3, 1'b1, 16'h043B);
    wait_drain("illegal_drain");
    check("err_set", DW'(bus.err_illegal_len), DW'(1));
    cyc(5);
    check("err_sticky", DW'(bus.err_illegal_len), DW'(1));

    // Reset during beat 2 of a 4-line burst
    for (int k = 0; k < 4; k++) begin
      load(0, 2'b11, 1'b0, 16'h0540 + 16'(k));
    end
    load(1, 2'b00, 1'b0, 16'h054F);
    expect_beat(0, 1'b1, 16'h0540);
    expect_beat(1, 1'b1, 16'h054F);
    cyc(1);
    rst   = 1'b1;
    rd[0] = wr[0];
    cyc(1);
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_grant", DW'(bus.req_ready), DW'(4'b0010));
    wait_drain("rst_drain");
    check("rst_err", DW'(bus.err_illegal_len), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
